// File: rtl/io_bus_reader.sv
// Bus initiator for the 24-bit vda/rw/ad/db/rdy I/O bus: reads a block of bytes (optionally
// preceded by a strobe write each) from a responder and queues them in a FIFO for a consumer.
module io_bus_reader #(
  parameter int FIFO_DEPTH = 16,
  parameter int TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [23:0] cmd_addr,
  input  logic [4:0]  cmd_len,
  input  logic        cmd_inc,
  input  logic        cmd_strobe,
  input  logic [23:0] cmd_strobe_addr,
  input  logic [7:0]  cmd_strobe_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        vda,
  output logic        rw,
  output logic [23:0] ad,
  inout  wire  [7:0]  db,
  input  logic        rdy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] FULL      = CW'(FIFO_DEPTH);
  localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, SPACE, STROBE, GAP1, READ, GAP2} state_t;
  state_t state, state_d;

  logic [4:0]    len_r, len_d;
  logic [23:0]   addr_r, addr_d, saddr_r, saddr_d;
  logic [7:0]    sdata_r, sdata_d;
  logic          inc_r, inc_d, strobe_r, strobe_d;
  logic [TW-1:0] wait_r, wait_d;
  logic          vda_d, rw_d, done_d, err_d;
  logic [23:0]   ad_d;
  logic          push, pop, launch, l_strobe;
  logic [23:0]   l_addr, l_saddr;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (count != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : 8'h00;
  assign pop       = out_ready && out_valid;
  assign db        = (vda && !rw) ? sdata_r : 8'hzz;

  always_comb begin
    state_d  = state;
    len_d    = len_r;
    addr_d   = addr_r;
    inc_d    = inc_r;
    strobe_d = strobe_r;
    saddr_d  = saddr_r;
    sdata_d  = sdata_r;
    wait_d   = wait_r;
    vda_d    = 1'b0;
    rw_d     = 1'b1;
    ad_d     = ad;
    done_d   = 1'b0;
    err_d    = 1'b0;
    push     = 1'b0;
    launch   = 1'b0;
    l_strobe = strobe_r;
    l_addr   = addr_r;
    l_saddr  = saddr_r;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          len_d    = cmd_len;
          addr_d   = cmd_addr;
          inc_d    = cmd_inc;
          strobe_d = cmd_strobe;
          saddr_d  = cmd_strobe_addr;
          sdata_d  = cmd_strobe_data;
          l_strobe = cmd_strobe;
          l_addr   = cmd_addr;
          l_saddr  = cmd_strobe_addr;
          if (cmd_len == 5'd0) done_d = 1'b1;
          else                 launch = 1'b1;
        end
      end
      SPACE: launch = 1'b1;
      STROBE, READ: begin
        if (rdy) begin
          if (state == STROBE) begin
            state_d = GAP1;
          end else begin
            push    = 1'b1;
            len_d   = len_r - 5'd1;
            addr_d  = addr_r + {23'd0, inc_r};
            done_d  = (len_r == 5'd1);
            state_d = GAP2;
          end
        end else if (wait_r == WAIT_LAST) begin
          // Responder never answered: abandon the rest of the command.
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          wait_d = wait_r + TW'(1);
          vda_d  = 1'b1;
          rw_d   = rw;
        end
      end
      GAP1: begin
        state_d = READ;
        wait_d  = '0;
        vda_d   = 1'b1;
        ad_d    = addr_r;
      end
      GAP2: begin
        if (len_r == 5'd0) state_d = IDLE;
        else               launch  = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // A read is only started when its byte is guaranteed a FIFO slot.
    if (launch) begin
      if (count < FULL) begin
        wait_d = '0;
        vda_d  = 1'b1;
        if (l_strobe) begin
          state_d = STROBE;
          rw_d    = 1'b0;
          ad_d    = l_saddr;
        end else begin
          state_d = READ;
          ad_d    = l_addr;
        end
      end else begin
        state_d = SPACE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      len_r  <= 5'd0;
      wait_r <= '0;
      vda    <= 1'b0;
      rw     <= 1'b1;
      ad     <= 24'd0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_d;
      len_r  <= len_d;
      wait_r <= wait_d;
      vda    <= vda_d;
      rw     <= rw_d;
      ad     <= ad_d;
      done   <= done_d;
      err    <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    addr_r   <= addr_d;
    inc_r    <= inc_d;
    strobe_r <= strobe_d;
    saddr_r  <= saddr_d;
    sdata_r  <= sdata_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= db;
  end

endmodule

// File: tb/tb_io_bus_reader.sv
// Bench for io_bus_reader: wait-state responder, transaction log and byte-stream reference model.
module tb_io_bus_reader;
  localparam int TO = 255;

  typedef struct packed {
    logic        wr_n;
    logic [23:0] a;
    logic [7:0]  d;
  } tx_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_inc, cmd_strobe;
  logic [23:0] cmd_addr, cmd_strobe_addr;
  logic [4:0]  cmd_len;
  logic [7:0]  cmd_strobe_data;
  logic        busy, done, err, out_valid, out_ready;
  logic [7:0]  out_data;
  logic        vda, rw, rdy;
  logic [23:0] ad;
  wire  [7:0]  db;

  io_bus_reader #(.FIFO_DEPTH(16), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .cmd_inc(cmd_inc), .cmd_strobe(cmd_strobe), .cmd_strobe_addr(cmd_strobe_addr),
    .cmd_strobe_data(cmd_strobe_data), .busy(busy), .done(done), .err(err),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .vda(vda), .rw(rw), .ad(ad), .db(db), .rdy(rdy)
  );

  always #5 clk = ~clk;

  // Responder: data depends on address and on how many reads it has served.
  function automatic logic [7:0] resp_byte(input logic [23:0] a, input int k);
    return a[7:0] ^ a[15:8] ^ 8'(k * 91 + 17);
  endfunction

  int   rd_k = 0, wcnt = 0, wait_n = 0;
  logic stuck = 1'b0;
  assign rdy = !stuck && vda && (wcnt >= wait_n);
  assign db  = (vda && rw) ? resp_byte(ad, rd_k) : 8'hzz;

  tx_t        tx_log[$];
  logic [7:0] got_b[$];
  int cyc = 0, acc_cnt = 0, acc_cyc = 0, done_cnt = 0, done_cyc = 0, err_cnt = 0;
  int vda_hi = 0, run = 0, last_run = 0, proto_bad = 0;
  logic prev_end = 1'b0, prev_vda = 1'b0, prev_rw = 1'b1;
  logic [23:0] prev_ad = 24'd0;

  always @(posedge clk) begin
    cyc  <= cyc + 1;
    wcnt <= (vda && !rdy) ? wcnt + 1 : 0;
    run  <= vda ? run + 1 : 0;
    if (!vda && run != 0) last_run <= run;
    if (rst_n) begin
      if (vda) vda_hi <= vda_hi + 1;
      if (vda && rdy) begin
        if (rw) begin
          tx_log.push_back({1'b1, ad, 8'h00});
          rd_k <= rd_k + 1;
        end else begin
          tx_log.push_back({1'b0, ad, db});
        end
      end
      proto_bad <= proto_bad + int'(prev_end && vda) + int'(done && err)
                 + int'(vda && prev_vda && !prev_end && (ad != prev_ad || rw != prev_rw));
      if (cmd_valid && cmd_ready) begin acc_cnt <= acc_cnt + 1; acc_cyc <= cyc; end
      if (done) begin done_cnt <= done_cnt + 1; done_cyc <= cyc; end
      if (err) err_cnt <= err_cnt + 1;
      if (out_valid && out_ready) got_b.push_back(out_data);
    end
    prev_end <= vda && rdy;
    prev_vda <= vda;
    prev_ad  <= ad;
    prev_rw  <= rw;
  end

  int n_total = 0, n_bad = 0;
  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  tx_t        exp_tx[$];
  logic [7:0] exp_b[$];
  int mk = 0, tx_rd = 0, got_rd = 0;
  logic rand_rdy = 1'b0;

  task automatic model_cmd(input logic [23:0] a, input int len, input logic inc,
                           input logic st, input logic [23:0] sa, input logic [7:0] sd);
    logic [23:0] cur;
    cur = a;
    for (int i = 0; i < len; i++) begin
      if (st) exp_tx.push_back({1'b0, sa, sd});
      exp_tx.push_back({1'b1, cur, 8'h00});
      exp_b.push_back(resp_byte(cur, mk));
      mk++;
      cur = cur + (inc ? 24'd1 : 24'd0);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (rand_rdy) out_ready = ($urandom_range(0, 1) == 1);
  endtask

  task automatic issue(input logic [23:0] a, input int len, input logic inc,
                       input logic st, input logic [23:0] sa, input logic [7:0] sd);
    int a0;
    a0 = acc_cnt;
    cmd_addr = a; cmd_len = 5'(len); cmd_inc = inc;
    cmd_strobe = st; cmd_strobe_addr = sa; cmd_strobe_data = sd;
    cmd_valid = 1'b1;
    for (int i = 0; i < 3000 && acc_cnt == a0; i++) tick();
    cmd_valid = 1'b0;
    check_eq("accept", 64'(acc_cnt - a0), 64'd1);
  endtask

  task automatic wait_done(input string tag, input int d0, input int maxc);
    for (int i = 0; i < maxc && (done_cnt + err_cnt) == d0; i++) tick();
    check_eq({tag, " finished"}, 64'(done_cnt + err_cnt != d0), 64'd1);
  endtask

  task automatic drain(input string tag);
    rand_rdy  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 100 && out_valid; i++) tick();
    tick();
    check_eq({tag, " drained"}, 64'(out_valid), 64'd0);
    out_ready = 1'b0;
  endtask

  task automatic check_tx(input string tag);
    int n;
    n = tx_log.size() - tx_rd;
    check_eq({tag, " tx count"}, 64'(n), 64'(exp_tx.size()));
    for (int i = 0; i < n && i < exp_tx.size(); i++)
      check_eq({tag, " tx"}, 64'(tx_log[tx_rd + i]), 64'(exp_tx[i]));
    tx_rd = tx_log.size();
    exp_tx.delete();
  endtask

  task automatic check_bytes(input string tag);
    int n;
    n = got_b.size() - got_rd;
    check_eq({tag, " byte count"}, 64'(n), 64'(exp_b.size()));
    for (int i = 0; i < n && i < exp_b.size(); i++)
      check_eq({tag, " byte"}, 64'(got_b[got_rd + i]), 64'(exp_b[i]));
    got_rd = got_b.size();
    exp_b.delete();
  endtask

  initial begin
    int d0, e0, dn0, vh0;
    logic [23:0] a1, a2;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_inc = 1'b0;
    cmd_strobe = 1'b0; cmd_strobe_addr = '0; cmd_strobe_data = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst vda", 64'(vda), 64'd0);
    check_eq("rst rw", 64'(rw), 64'd1);
    check_eq("rst ad", 64'(ad), 64'd0);
    check_eq("rst busy", 64'(busy), 64'd0);
    check_eq("rst done/err", 64'({done, err}), 64'd0);
    check_eq("rst out_valid", 64'(out_valid), 64'd0);
    check_eq("rst out_data", 64'(out_data), 64'd0);
    check_eq("rst cmd_ready", 64'(cmd_ready), 64'd1);
    rst_n = 1'b1;
    tick();

    // Two wait states, incrementing reads
    wait_n = 2;
    d0 = done_cnt + err_cnt; vh0 = vda_hi;
    model_cmd(24'hFEA108, 4, 1'b1, 1'b0, 24'h0, 8'h0);
    issue(24'hFEA108, 4, 1'b1, 1'b0, 24'h0, 8'h0);
    wait_done("t1", d0, 200);
    check_eq("t1 done latency", 64'(done_cyc - acc_cyc), 64'd16);
    check_eq("t1 vda cycles", 64'(vda_hi - vh0), 64'd12);
    check_tx("t1");
    drain("t1");
    check_bytes("t1");

    // Strobe before each read, fixed address
    wait_n = $urandom_range(0, 3);
    d0 = done_cnt + err_cnt;
    model_cmd(24'hFEA108, 2, 1'b0, 1'b1, 24'hFEA10E, 8'h00);
    issue(24'hFEA108, 2, 1'b0, 1'b1, 24'hFEA10E, 8'h00);
    wait_done("t2", d0, 200);
    check_tx("t2");
    drain("t2");
    check_bytes("t2");

    // Zero-length command
    d0 = done_cnt + err_cnt;
    issue(24'h123456, 0, 1'b1, 1'b1, 24'h000001, 8'h55);
    wait_done("t3", d0, 20);
    check_eq("t3 done latency", 64'(done_cyc - acc_cyc), 64'd1);
    check_tx("t3");

    // FIFO full stall across two 16-byte commands
    wait_n = $urandom_range(0, 2);
    a1 = 24'($urandom); a2 = 24'($urandom);
    model_cmd(a1, 16, 1'b1, 1'b0, 24'h0, 8'h0);
    model_cmd(a2, 16, 1'b1, 1'b0, 24'h0, 8'h0);
    d0 = done_cnt + err_cnt;
    issue(a1, 16, 1'b1, 1'b0, 24'h0, 8'h0);
    wait_done("t4a", d0, 1000);
    d0 = done_cnt + err_cnt;
    issue(a2, 16, 1'b1, 1'b0, 24'h0, 8'h0);
    repeat (40) tick();
    check_eq("t4 stall busy", 64'(busy), 64'd1);
    check_eq("t4 stall reads", 64'(tx_log.size() - tx_rd), 64'd16);
    check_eq("t4 stall out_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    wait_done("t4b", d0, 1000);
    check_tx("t4");
    drain("t4");
    check_bytes("t4");

    // Timeout after one byte already queued
    wait_n = 0; stuck = 1'b0;
    a1 = 24'($urandom);
    e0 = err_cnt; dn0 = done_cnt; d0 = done_cnt + err_cnt;
    model_cmd(a1, 1, 1'b1, 1'b0, 24'h0, 8'h0);
    issue(a1, 3, 1'b1, 1'b0, 24'h0, 8'h0);
    for (int i = 0; i < 50 && tx_log.size() == tx_rd; i++) tick();
    stuck = 1'b1;
    wait_done("t5", d0, 600);
    tick();
    check_eq("t5 err pulses", 64'(err_cnt - e0), 64'd1);
    check_eq("t5 done pulses", 64'(done_cnt - dn0), 64'd0);
    check_eq("t5 vda run", 64'(last_run), 64'(TO));
    check_eq("t5 idle", 64'({busy, cmd_ready}), 64'b01);
    stuck = 1'b0;
    check_tx("t5");
    check_eq("t5 kept byte", 64'(out_valid), 64'd1);
    drain("t5");
    check_bytes("t5");

    // Address wrap
    wait_n = 1;
    d0 = done_cnt + err_cnt;
    model_cmd(24'hFFFFFF, 2, 1'b1, 1'b0, 24'h0, 8'h0);
    issue(24'hFFFFFF, 2, 1'b1, 1'b0, 24'h0, 8'h0);
    wait_done("t6", d0, 100);
    check_tx("t6");
    drain("t6");
    check_bytes("t6");

    // Reset during a read cycle with bytes queued
    wait_n = 0;
    d0 = done_cnt + err_cnt;
    model_cmd(24'h004000, 2, 1'b1, 1'b0, 24'h0, 8'h0);
    issue(24'h004000, 2, 1'b1, 1'b0, 24'h0, 8'h0);
    wait_done("t7a", d0, 100);
    check_tx("t7a");
    exp_b.delete();
    stuck = 1'b1;
    issue(24'h005000, 3, 1'b1, 1'b0, 24'h0, 8'h0);
    for (int i = 0; i < 20 && !vda; i++) tick();
    repeat (2) tick();
    check_eq("t7 pre vda", 64'(vda), 64'd1);
    rst_n = 1'b0;
    tick();
    check_eq("t7 vda", 64'(vda), 64'd0);
    check_eq("t7 out_valid", 64'(out_valid), 64'd0);
    check_eq("t7 busy", 64'(busy), 64'd0);
    rst_n = 1'b1; stuck = 1'b0;
    tick();
    check_tx("t7");

    // Randomized commands with random consumer back-pressure
    rand_rdy = 1'b1;
    for (int n = 0; n < 25; n++) begin
      logic [23:0] ra, rsa;
      logic [7:0]  rsd;
      int          rl;
      logic        ri, rs;
      wait_n = $urandom_range(0, 3);
      ra = 24'($urandom); rsa = 24'($urandom); rsd = 8'($urandom);
      rl = $urandom_range(0, 16); ri = 1'($urandom); rs = 1'($urandom);
      d0 = done_cnt + err_cnt;
      model_cmd(ra, rl, ri, rs, rsa, rsd);
      issue(ra, rl, ri, rs, rsa, rsd);
      wait_done("rand", d0, 3000);
      check_tx("rand");
    end
    drain("rand");
    check_bytes("rand");

    check_eq("protocol", 64'(proto_bad), 64'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
